// File: rtl/comb_filter_var.sv
// Variable-delay feedback comb filter for I/Q sample pairs with a 1-cycle registered output.
// Define COMB_FILTER_HIST_CLEAR_EN to add the CLEAR sweep that zeroes history and drives busy.
module comb_filter_var #(
    parameter int BIT_WIDTH  = 16,
    parameter int DELAY_LOG2 = 3,
    parameter int FB_SHIFT   = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  strobe_in,
    input  logic [BIT_WIDTH-1:0]  i_in,
    input  logic [BIT_WIDTH-1:0]  q_in,
    input  logic [DELAY_LOG2-1:0] delay_sel,
    input  logic                  bypass,
    output logic                  strobe_out,
    output logic [BIT_WIDTH-1:0]  i_out,
    output logic [BIT_WIDTH-1:0]  q_out,
    output logic                  busy
);
    localparam int W     = BIT_WIDTH + FB_SHIFT;
    localparam int DEPTH = 1 << DELAY_LOG2;

    logic [DELAY_LOG2-1:0] r_delay;
    logic [DELAY_LOG2-1:0] r_ptr;
    logic                  r_strobe;
    logic [BIT_WIDTH-1:0]  r_iOut;
    logic [BIT_WIDTH-1:0]  r_qOut;
    logic signed [W-1:0]   r_histI [DEPTH];
    logic signed [W-1:0]   r_histQ [DEPTH];

    logic                  w_delayChange;
    logic                  w_busy;
    logic                  w_clrWrite;
    logic                  w_zeroOut;
    logic                  w_accept;
    logic                  w_update;
    logic [DELAY_LOG2-1:0] w_clrIdx;
    logic signed [W-1:0]   w_xI;
    logic signed [W-1:0]   w_xQ;
    logic signed [W-1:0]   w_hI;
    logic signed [W-1:0]   w_hQ;
    logic signed [W-1:0]   w_sumI;
    logic signed [W-1:0]   w_sumQ;

    // A strobe coinciding with a delay change is dropped so the new delay starts from slot 0.
    assign w_delayChange = (delay_sel != r_delay);
    assign w_accept      = strobe_in && !w_busy && !w_delayChange;
    assign w_update      = w_accept && !bypass;

    assign w_xI   = W'(signed'(i_in));
    assign w_xQ   = W'(signed'(q_in));
    assign w_hI   = r_histI[r_ptr];
    assign w_hQ   = r_histQ[r_ptr];
    assign w_sumI = w_xI - w_hI + (w_hI >>> FB_SHIFT);
    assign w_sumQ = w_xQ - w_hQ + (w_hQ >>> FB_SHIFT);

`ifdef COMB_FILTER_HIST_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [DELAY_LOG2-1:0] r_clrIdx;
    logic [DELAY_LOG2-1:0] w_clrIdxNext;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_CLEAR;
            r_clrIdx <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_clrIdx <= w_clrIdxNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_clrIdxNext = r_clrIdx;
        w_clrWrite   = 1'b0;
        w_zeroOut    = 1'b0;
        w_busy       = (r_state == ST_CLEAR);
        if (w_delayChange) begin
            w_stateNext  = ST_CLEAR;
            w_clrIdxNext = '0;
            w_zeroOut    = 1'b1;
        end else if (r_state == ST_CLEAR) begin
            w_clrWrite = 1'b1;
            w_zeroOut  = 1'b1;
            if (&r_clrIdx) begin
                w_stateNext = ST_RUN;
            end else begin
                w_clrIdxNext = r_clrIdx + 1'b1;
            end
        end
    end

    assign w_clrIdx = r_clrIdx;
`else
    assign w_busy     = 1'b0;
    assign w_clrWrite = 1'b0;
    assign w_zeroOut  = 1'b0;
    assign w_clrIdx   = '0;
`endif

    // History has no reset so it can map onto RAM; the clear sweep owns its initial contents.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (w_clrWrite) begin
                r_histI[w_clrIdx] <= '0;
                r_histQ[w_clrIdx] <= '0;
            end else if (w_update) begin
                r_histI[r_ptr] <= w_sumI;
                r_histQ[r_ptr] <= w_sumQ;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_delay  <= delay_sel;
            r_ptr    <= '0;
            r_strobe <= 1'b0;
            r_iOut   <= '0;
            r_qOut   <= '0;
        end else begin
            r_delay  <= delay_sel;
            r_strobe <= w_accept;
            if (w_delayChange) begin
                r_ptr <= '0;
            end else if (w_update) begin
                r_ptr <= (r_ptr == r_delay) ? '0 : r_ptr + 1'b1;
            end
            if (w_zeroOut) begin
                r_iOut <= '0;
                r_qOut <= '0;
            end else if (w_accept) begin
                if (bypass) begin
                    r_iOut <= i_in;
                    r_qOut <= q_in;
                end else begin
                    r_iOut <= w_sumI[W-1:FB_SHIFT];
                    r_qOut <= w_sumQ[W-1:FB_SHIFT];
                end
            end
        end
    end

    assign strobe_out = r_strobe;
    assign i_out      = r_iOut;
    assign q_out      = r_qOut;
    assign busy       = w_busy;

endmodule

// File: tb/tb_comb_filter_var.sv
// Scoreboard bench for comb_filter_var: randomized stimulus against an arithmetic reference model.
// Expectations follow COMB_FILTER_HIST_CLEAR_EN when it is defined for the build.
module tb_comb_filter_var;
    localparam int BW    = 16;
    localparam int DL    = 3;
    localparam int FS    = 3;
    localparam int W     = BW + FS;
    localparam int DEPTH = 1 << DL;
`ifdef COMB_FILTER_HIST_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef struct {
        int edgeNo;
        int iVal;
        int qVal;
        bit known;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic          strobe_in;
    logic [BW-1:0] i_in;
    logic [BW-1:0] q_in;
    logic [DL-1:0] delay_sel;
    logic          bypass;
    logic          strobe_out;
    logic [BW-1:0] i_out;
    logic [BW-1:0] q_out;
    logic          busy;

    exp_t expQ[$];
    int   obsI[$];
    int   obsQ[$];
    int   checks = 0;
    int   failures = 0;
    int   edgeCnt = 0;
    bit   modelValid = 1'b0;
    bit   lastBusy;
    int   busyCnt;

    int mHist[2][DEPTH];
    bit mKnown[DEPTH];
    int mP;
    int mDelay;
    int mClear;
    int mHeld[2];
    bit mHeldKnown;

    comb_filter_var #(.BIT_WIDTH(BW), .DELAY_LOG2(DL), .FB_SHIFT(FS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .strobe_in  (strobe_in),
        .i_in       (i_in),
        .q_in       (q_in),
        .delay_sel  (delay_sel),
        .bypass     (bypass),
        .strobe_out (strobe_out),
        .i_out      (i_out),
        .q_out      (q_out),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at edge %0d", name, act, exp, edgeCnt);
        end
    endtask

    function automatic int wrapW(input int v);
        int m;
        m = v & ((1 << W) - 1);
        if (m >= (1 << (W - 1))) m -= (1 << W);
        return m;
    endfunction

    // Reference filter: new = x - old + old/8 (floor), wrapped to W bits; output drops FS low bits.
    function automatic int combOut(input int ch, input int x);
        int h;
        int s;
        h = mHist[ch][mP];
        s = wrapW(x - h + (h >>> FS));
        mHist[ch][mP] = s;
        return (s >>> FS) & 'hFFFF;
    endfunction

    task automatic modelStep();
        int  x[2];
        int  slot;
        bit  busyNow;
        bit  change;
        bit  accept;
        if (!reset_n) begin
            mP         = 0;
            mDelay     = int'(delay_sel);
            mHeld[0]   = 0;
            mHeld[1]   = 0;
            mHeldKnown = 1'b1;
            mClear     = CLR_EN ? DEPTH : 0;
            foreach (mKnown[k]) mKnown[k] = 1'b0;
            modelValid = 1'b1;
            return;
        end
        x[0]    = int'($signed(i_in));
        x[1]    = int'($signed(q_in));
        busyNow = (mClear > 0);
        change  = (int'(delay_sel) != mDelay);
        accept  = strobe_in && !busyNow && !change;
        if (busyNow && !change) begin
            slot           = DEPTH - mClear;
            mHist[0][slot] = 0;
            mHist[1][slot] = 0;
            mKnown[slot]   = 1'b1;
            mClear--;
        end
        if (change) begin
            mP     = 0;
            mClear = CLR_EN ? DEPTH : 0;
        end
        if ((CLR_EN && change) || busyNow) begin
            mHeld[0]   = 0;
            mHeld[1]   = 0;
            mHeldKnown = 1'b1;
        end else if (accept) begin
            if (bypass) begin
                mHeld[0]   = x[0] & 'hFFFF;
                mHeld[1]   = x[1] & 'hFFFF;
                mHeldKnown = 1'b1;
            end else begin
                mHeldKnown = mKnown[mP];
                mHeld[0]   = combOut(0, x[0]);
                mHeld[1]   = combOut(1, x[1]);
                mP         = (mP == mDelay) ? 0 : mP + 1;
            end
            expQ.push_back('{edgeCnt + 1, mHeld[0], mHeld[1], mHeldKnown});
        end
        mDelay = int'(delay_sel);
    endtask

    task automatic checkHeld();
        compare("busy", int'(busy), (mClear > 0) ? 1 : 0);
        if (mHeldKnown) begin
            compare("i_out_held", int'(i_out), mHeld[0]);
            compare("q_out_held", int'(q_out), mHeld[1]);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit stb, input logic [BW-1:0] iv,
                                 input logic [BW-1:0] qv, input logic [DL-1:0] d, input bit byp);
        @(negedge clock);
        lastBusy = busy;
        if (modelValid) checkHeld();
        reset_n   = !rst;
        strobe_in = stb;
        i_in      = iv;
        q_in      = qv;
        delay_sel = d;
        bypass    = byp;
        modelStep();
    endtask

    task automatic checkOutput();
        exp_t e;
        obsI.push_back(int'(i_out));
        obsQ.push_back(int'(q_out));
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_strobe_out actual=1 expected=0 at edge %0d", edgeCnt);
            return;
        end
        e = expQ.pop_front();
        compare("strobe_latency_edge", edgeCnt, e.edgeNo);
        if (e.known) begin
            compare("i_out", int'(i_out), e.iVal);
            compare("q_out", int'(q_out), e.qVal);
        end
    endtask

    task automatic expectLog(input string name, input int idx, input int expI, input int expQv);
        if (idx >= obsI.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s missing output #%0d (have %0d) expected i=0x%0h", name, idx, obsI.size(), expI);
        end else begin
            compare({name, "_i"}, obsI[idx], expI);
            compare({name, "_q"}, obsQ[idx], expQv);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            edgeCnt++;
            if (strobe_out === 1'b1) begin
                checkOutput();
            end else if (expQ.size() > 0 && expQ[0].edgeNo <= edgeCnt) begin
                compare("strobe_out_missing", int'(strobe_out), 1);
                void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DL-1:0] d;
        reset_n   = 1'b0;
        strobe_in = 1'b0;
        i_in      = '0;
        q_in      = '0;
        delay_sel = 3'd3;
        bypass    = 1'b0;

        // Reset for 3 cycles, then strobe every cycle through the clear sweep.
        repeat (3) applyStimulus(1'b1, 1'b1, 16'h0, 16'h0, 3'd3, 1'b0);
        busyCnt = 0;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 1'b1, 16'h0, 16'h0, 3'd3, 1'b0);
            if (lastBusy) busyCnt++;
        end

        // Impulse with D=4.
        obsI.delete();
        obsQ.delete();
        applyStimulus(1'b0, 1'b1, 16'h1000, 16'h0, 3'd3, 1'b0);
        if (lastBusy) busyCnt++;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 1'b1, 16'h0, 16'h0, 3'd3, 1'b0);
            if (lastBusy) busyCnt++;
        end
        compare("busy_cycles_after_reset", busyCnt, CLR_EN ? 8 : 0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd3, 1'b0);
`ifdef COMB_FILTER_HIST_CLEAR_EN
        expectLog("impulse0", 0, 'h0200, 0);
        expectLog("impulse1", 1, 0, 0);
        expectLog("impulse3", 3, 0, 0);
        expectLog("impulse4", 4, 'hFE40, 0);
        expectLog("impulse8", 8, 'h0188, 0);
`endif

        // D=1 with a constant input: change cycle dropped, sweep, then recursion.
        obsI.delete();
        obsQ.delete();
        for (int n = 0; n < 12; n++) applyStimulus(1'b0, 1'b1, 16'h0800, 16'h0800, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
`ifdef COMB_FILTER_HIST_CLEAR_EN
        expectLog("wrap0", 0, 'h0100, 'h0100);
        expectLog("wrap1", 1, 'h0020, 'h0020);
        expectLog("wrap2", 2, 'h00E4, 'h00E4);
`endif

        // Bypass passes input through unchanged.
        obsI.delete();
        obsQ.delete();
        applyStimulus(1'b0, 1'b1, 16'h1234, 16'h5678, 3'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        expectLog("bypass", 0, 'h1234, 'h5678);

        // Delay change mid-stream: busy window, then history reads zero.
        obsI.delete();
        obsQ.delete();
        busyCnt = 0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b0, 1'b1, 16'h0400, 16'hFC00, 3'd5, 1'b0);
            if (lastBusy) busyCnt++;
        end
        compare("busy_cycles_after_delay_change", busyCnt, CLR_EN ? 8 : 0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd5, 1'b0);
`ifdef COMB_FILTER_HIST_CLEAR_EN
        expectLog("after_clear", 0, 'h0080, 'hFF80);
`endif

        // Randomized traffic with occasional bypass and delay changes.
        d = 3'd5;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) d = 3'($urandom_range(0, 7));
            applyStimulus(1'b0, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), d,
                          $urandom_range(0, 9) == 0);
        end

        // Reset while the sweep is at slot 4; the full sweep must repeat.
        d = d + 3'd1;
        applyStimulus(1'b0, 1'b1, 16'($urandom), 16'($urandom), d, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1, 16'($urandom), 16'($urandom), d, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b1, 16'($urandom), 16'($urandom), d, 1'b0);
        busyCnt = 0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b0, 1'b1, 16'($urandom), 16'($urandom), d, 1'b0);
            if (lastBusy) busyCnt++;
        end
        compare("busy_cycles_after_midclear_reset", busyCnt, CLR_EN ? 8 : 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 49) == 0) d = 3'($urandom_range(0, 7));
            applyStimulus(1'b0, $urandom_range(0, 4) != 0, 16'($urandom), 16'($urandom), d,
                          $urandom_range(0, 7) == 0);
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, d, 1'b0);
        compare("pending_expected_outputs", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
